// File: rtl/cheri_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cheri_pkg
// Description : Shared types and constants for the CHERI load-tag revocation
//               pipeline (FSM states, FIFO entry layout, idle parity word).
// Revision    : 1.0 - initial release
// ============================================================================
package cheri_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } trvk_state_e;

    typedef struct packed {
        logic [4:0]  waddr;
        logic        tag;
        logic [31:0] base;
    } trvk_entry_t;

    // Inverted SECDED check bits of an all-zero 32-bit word
    localparam logic [6:0] NullParBits = 7'h2a;

endpackage
`default_nettype wire

// File: rtl/prim_secded_inv_39_32_enc.sv
`default_nettype none
// ============================================================================
// Module      : prim_secded_inv_39_32_enc
// Description : Hsiao SECDED (39,32) encoder with inverted check bits, so an
//               all-zero data word never yields an all-zero codeword.
// Revision    : 1.0 - initial release
// ============================================================================
module prim_secded_inv_39_32_enc (
    input  logic [31:0] data_i,
    output logic [38:0] data_o
);

    logic [38:0] w_d;
    logic [6:0]  w_chk;

    assign w_d = {7'h0, data_i};

    assign w_chk = {
        ^(w_d & 39'h0098505586),
        ^(w_d & 39'h002DCC624C),
        ^(w_d & 39'h00C2C1323B),
        ^(w_d & 39'h0031234ED1),
        ^(w_d & 39'h00413D89AA),
        ^(w_d & 39'h00DEBA8050),
        ^(w_d & 39'h002606BD25)
    };

    assign data_o = {w_chk ^ 7'h2a, data_i};

endmodule
`default_nettype wire

// File: rtl/cheri_trvk_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cheri_trvk_pipe
// Description : Tracks completed capability loads, looks up the revocation
//               bitmap for tagged heap capabilities and releases the reserved
//               register with a tag-clear verdict, strictly in load order.
//               Optional macro CHERI_TRVK_PAR_EN adds SECDED check bits on the
//               register-file reservation/release buses.
// Revision    : 1.0 - initial release
// ============================================================================
module cheri_trvk_pipe
    import cheri_pkg::*;
#(
    parameter logic [31:0] HeapBase  = 32'h8000_0000,
    parameter logic [31:0] HeapTop   = 32'h8004_0000,
    parameter logic [31:0] RvkBase   = 32'h8300_0000,
    parameter int unsigned FifoDepth = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clc_valid_i,
    output logic        clc_ready_o,
    input  logic [4:0]  clc_waddr_i,
    input  logic        clc_tag_i,
    input  logic [31:0] clc_base_i,
    output logic        rvk_req_o,
    output logic [31:0] rvk_addr_o,
    input  logic        rvk_gnt_i,
    input  logic        rvk_rvalid_i,
    input  logic [31:0] rvk_rdata_i,
    output logic        trsv_en_o,
    output logic [4:0]  trsv_addr_o,
    output logic [6:0]  trsv_par_o,
    output logic        trvk_en_o,
    output logic [4:0]  trvk_addr_o,
    output logic        trvk_clrtag_o,
    output logic [6:0]  trvk_par_o,
    output logic        busy_o
);

    localparam int unsigned       c_PW   = (FifoDepth > 2) ? 2 : 1;
    localparam logic [c_PW-1:0]   c_LAST = c_PW'(FifoDepth - 1);
    localparam logic [2:0]        c_FULL = 3'(FifoDepth);

    trvk_entry_t      r_mem [FifoDepth];
    logic [c_PW-1:0]  r_wptr;
    logic [c_PW-1:0]  r_rptr;
    logic [2:0]       r_count;
    trvk_state_e      r_state;
    logic             r_rvk_req;
    logic [31:0]      r_rvk_addr;
    logic             r_trvk_en;
    logic [4:0]       r_trvk_addr;
    logic             r_trvk_clrtag;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    trvk_entry_t      w_in;
    trvk_entry_t      w_head;
    logic             w_head_vld;
    logic             w_in_range;
    logic [31:0]      w_idx;
    logic [31:0]      w_lookup_addr;

    function automatic logic [c_PW-1:0] f_next(input logic [c_PW-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_full      = (r_count == c_FULL);
    assign w_empty     = (r_count == 3'd0);
    assign clc_ready_o = rst_i | ~w_full;
    assign w_push      = clc_valid_i & ~w_full & ~rst_i;
    assign trsv_en_o   = w_push;
    assign trsv_addr_o = w_push ? clc_waddr_i : 5'd0;

    // An empty FIFO forwards the incoming load so the no-lookup path has
    // single-cycle latency; push and pop then cancel in the count.
    assign w_in       = '{waddr: clc_waddr_i, tag: clc_tag_i, base: clc_base_i};
    assign w_head     = w_empty ? w_in : r_mem[r_rptr];
    assign w_head_vld = ~w_empty | w_push;

    assign w_in_range    = (w_head.base >= HeapBase) && (w_head.base < HeapTop);
    assign w_idx         = (w_head.base - HeapBase) >> 3;
    assign w_lookup_addr = RvkBase + {3'b000, w_idx[31:5], 2'b00};

    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            ST_IDLE: w_pop = w_head_vld & ~(w_head.tag & w_in_range);
            ST_WAIT: w_pop = rvk_rvalid_i;
            default: w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_in;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 3'd0;
        end else begin
            if (w_push) begin
                r_wptr <= f_next(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_next(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_rvk_req     <= 1'b0;
            r_rvk_addr    <= 32'd0;
            r_trvk_en     <= 1'b0;
            r_trvk_addr   <= 5'd0;
            r_trvk_clrtag <= 1'b0;
        end else begin
            r_trvk_en     <= 1'b0;
            r_trvk_addr   <= 5'd0;
            r_trvk_clrtag <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_head_vld) begin
                        if (w_head.tag && w_in_range) begin
                            r_state    <= ST_REQ;
                            r_rvk_req  <= 1'b1;
                            r_rvk_addr <= w_lookup_addr;
                        end else begin
                            r_trvk_en   <= 1'b1;
                            r_trvk_addr <= w_head.waddr;
                        end
                    end
                end
                ST_REQ: begin
                    if (rvk_gnt_i) begin
                        r_rvk_req <= 1'b0;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (rvk_rvalid_i) begin
                        r_trvk_en     <= 1'b1;
                        r_trvk_addr   <= w_head.waddr;
                        r_trvk_clrtag <= rvk_rdata_i[w_idx[4:0]];
                        r_state       <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rvk_req_o     = r_rvk_req;
    assign rvk_addr_o    = r_rvk_addr;
    assign trvk_en_o     = r_trvk_en;
    assign trvk_addr_o   = r_trvk_addr;
    assign trvk_clrtag_o = r_trvk_clrtag;
    assign busy_o        = ~w_empty | (r_state != ST_IDLE);

`ifdef CHERI_TRVK_PAR_EN
    logic [38:0] w_trsv_cw;
    logic [38:0] w_trvk_cw;

    prim_secded_inv_39_32_enc u_trsv_enc (
        .data_i ({26'h0, trsv_en_o, trsv_addr_o}),
        .data_o (w_trsv_cw)
    );

    prim_secded_inv_39_32_enc u_trvk_enc (
        .data_i ({25'h0, trvk_en_o, trvk_clrtag_o, trvk_addr_o}),
        .data_o (w_trvk_cw)
    );

    assign trsv_par_o = w_trsv_cw[38:32];
    assign trvk_par_o = w_trvk_cw[38:32];
`else
    assign trsv_par_o = 7'h0;
    assign trvk_par_o = 7'h0;
`endif

endmodule
`default_nettype wire

// File: doc/cheri_trvk_pipe.md
CHERI_TRVK_PIPE -- requirements
Module: cheri_trvk_pipe

Interface
REQ-001 SHALL have parameter HeapBase, default 32'h8000_0000: lowest revocable heap byte address.
REQ-002 SHALL have parameter HeapTop, default 32'h8004_0000: exclusive upper heap bound.
REQ-003 SHALL have parameter RvkBase, default 32'h8300_0000: byte address of the revocation bitmap.
REQ-004 SHALL have parameter FifoDepth, default 2: pending capability-load entries; legal range 2..4.
REQ-005 SHALL have port clk_i, in, 1: the single clock.
REQ-006 SHALL have port rst_i, in, 1: reset, synchronous and active-high.
REQ-007 SHALL have port clc_valid_i, in, 1: capability load completed by the LSU.
REQ-008 SHALL have port clc_ready_o, out, 1: entry accepted.
REQ-009 SHALL have port clc_waddr_i, in, 5: destination register.
REQ-010 SHALL have port clc_tag_i, in, 1: loaded tag.
REQ-011 SHALL have port clc_base_i, in, 32: decoded capability base.
REQ-012 SHALL have ports rvk_req_o out 1, rvk_addr_o out 32, rvk_gnt_i in 1, rvk_rvalid_i in 1, rvk_rdata_i in 32: bitmap read port.
REQ-013 SHALL have ports trsv_en_o out 1, trsv_addr_o out 5, trsv_par_o out 7: register reservation toward the register file.
REQ-014 SHALL have ports trvk_en_o out 1, trvk_addr_o out 5, trvk_clrtag_o out 1, trvk_par_o out 7: register release and tag-clear toward the register file.
REQ-015 SHALL have port busy_o, out, 1: FIFO non-empty or FSM not in IDLE.

Function
REQ-016 SHALL drive clc_ready_o = !fifo_full; handshake = clc_valid_i & clc_ready_o.
REQ-017 On handshake SHALL drive, combinationally and in the same cycle: trsv_en_o=1, trsv_addr_o=clc_waddr_i; entry {waddr, tag, base} SHALL be pushed.
REQ-018 trsv_addr_o SHALL be 0 when trsv_en_o=0.
REQ-019 In-range SHALL mean HeapBase <= base < HeapTop, 32-bit unsigned compare.
REQ-020 Bit index SHALL be idx = (base-HeapBase)>>3; rvk_addr_o = RvkBase + {idx[31:5],2'b00}; bit select = idx[4:0].
REQ-021 FSM states SHALL be IDLE, REQ, WAIT.
REQ-022 IDLE, head present, tag=0 or out of range: SHALL issue a registered trvk pulse next cycle with clrtag=0, pop, and stay in IDLE.
REQ-023 IDLE, head present, tag=1 and in range: SHALL go to REQ.
REQ-024 REQ: rvk_req_o=1, rvk_addr_o held stable until rvk_gnt_i; on grant SHALL go to WAIT.
REQ-025 WAIT: on rvk_rvalid_i SHALL register trvk_en=1, addr=head waddr, clrtag=rvk_rdata_i[bit]; SHALL pop and return to IDLE.
REQ-026 trvk_en_o SHALL be a one-cycle pulse, at most one per cycle; entries SHALL complete strictly in FIFO order.
REQ-027 Latency SHALL be: tag=0 or out of range, 1 cycle; lookup, 1 cycle after rvalid.
REQ-028 Push and pop in the same cycle SHALL be legal when not full; count is unchanged.
REQ-029 Push while full SHALL not occur, since ready=0.
REQ-030 rvk_rvalid_i outside WAIT SHALL be ignored.
REQ-031 clc_waddr_i=0 SHALL be processed normally.

Reset
REQ-032 While rst_i=1 SHALL hold: FIFO empty, state IDLE, clc_ready_o=1, rvk_req_o=0, rvk_addr_o=0, trsv_en_o=0, trsv_addr_o=0, trvk_en_o=0, trvk_addr_o=0, trvk_clrtag_o=0, busy_o=0, par outputs as in REQ-035.
REQ-033 Reset asserted mid-lookup SHALL drop the outstanding request; a later rvalid SHALL be ignored.

Configuration
REQ-034 Macro CHERI_TRVK_PAR_EN defined: trsv_par_o SHALL be the inverted SECDED 39/32 check bits of {26'h0, trsv_en_o, trsv_addr_o}.
REQ-035 Macro CHERI_TRVK_PAR_EN defined: trvk_par_o SHALL be the same encoding of {25'h0, trvk_en_o, trvk_clrtag_o, trvk_addr_o}, giving 7'h2a when idle.
REQ-036 Macro CHERI_TRVK_PAR_EN undefined: both par outputs SHALL be tied to 7'h0 and no encoder SHALL be instantiated.

Structure
REQ-037 The FSM state enum and the NullParBits (7'h2a) constant SHALL live in cheri_pkg.
REQ-038 The sub-modules SHALL be two instances of prim_secded_inv_39_32_enc; FIFO and FSM SHALL be inline.

Verification
REQ-039 Tag=0 load, waddr=5: trsv_en pulse with addr 5 in the same cycle; next cycle trvk_en=1, addr=5, clrtag=0.
REQ-040 Tag=1, base=32'h8000_0108: rvk_addr_o=32'h8300_0004; rdata bit 1=1 -> trvk clrtag=1, addr=waddr.
REQ-041 Base=32'h9000_0000, tag=1: no rvk_req; trvk clrtag=0 after 1 cycle.
REQ-042 Three back-to-back pushes with gnt stalled: third push sees clc_ready_o=0; order of trvk addresses preserved.
REQ-043 rst_i high during WAIT, then rvalid=1: no trvk pulse, busy_o=0.
REQ-044 With CHERI_TRVK_PAR_EN defined, idle: trvk_par_o=7'h2a and trsv_par_o=7'h2a.
